ph_reg3_feeder: RTL and testbench
=================================

PH_REG3_FEEDER -- requirements
Module: ph_reg3_feeder

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 2: low width of p_westb_b, in p_clk cycles; legal range 1..15.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1: extra recovery cycles beyond synchroniser depth; legal range 0..15.
REQ-003 p_clk  in  1  parasite-side clock; all state on rising edge.
REQ-004 h_rst_b  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a block transfer.
REQ-006 byte_count  in  16  bytes to transfer; sampled with start.
REQ-007 one_byte_mode  in  1  register-3 V-flag mode; sampled with start.
REQ-008 abort  in  1  level request to terminate the transfer early.
REQ-009 s_data  in  8  source byte stream data.
REQ-010 s_valid  in  1  source byte valid.
REQ-011 s_ready  out  1  one-cycle accept strobe; a byte transfers when s_valid & s_ready.
REQ-012 p_full  in  1  register-3 parasite full flag, asynchronous to p_clk.
REQ-013 p_data  out  8  byte presented to register 3.
REQ-014 p_selectData  out  1  register-3 data select.
REQ-015 p_westb_b  out  1  active-low write strobe; register 3 latches on its rising edge.
REQ-016 busy  out  1  transfer in progress.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 aborted  out  1  qualifies done; set when termination was by abort.
REQ-019 err  out  1  one-cycle pulse on a rejected start.
REQ-020 remaining  out  16  bytes still to be written.

Function
REQ-021 p_full SHALL pass through a 2-flop synchroniser; the FSM uses only p_full_s.
REQ-022 FSM states SHALL be IDLE, WAIT_SPACE, SETUP, STROBE, HOLD, RECOVER, DONE.
REQ-023 IDLE: on start with byte_count!=0 and no odd/two-byte violation, load remaining and mode_q, then go to WAIT_SPACE.
REQ-024 IDLE: a start with byte_count==0 SHALL pulse done (aborted=0) the next cycle and stay IDLE.
REQ-025 IDLE: a start with mode=two-byte and odd byte_count SHALL pulse err the next cycle, leave remaining unchanged, and stay IDLE.
REQ-026 WAIT_SPACE -> SETUP when p_full_s==0 and s_valid==1; otherwise hold.
REQ-027 SETUP (1 cycle): s_ready=1, p_data<=s_data, p_selectData=1, p_westb_b=1.
REQ-028 STROBE: p_westb_b=0 for exactly STROBE_CYCLES cycles; p_data and p_selectData stable.
REQ-029 HOLD (1 cycle): p_westb_b=1, p_selectData=1, p_data held (hold time after latch edge); remaining decrements by 1 on entry.
REQ-030 RECOVER: p_selectData=0 for 2+SETTLE_CYCLES cycles, so p_full_s reflects the write; then go to DONE if remaining==0 or abort==1, else to WAIT_SPACE.
REQ-031 DONE (1 cycle): done=1, aborted=latched abort status; then go to IDLE.
REQ-032 abort in WAIT_SPACE SHALL go directly to DONE with aborted=1; abort in SETUP/STROBE/HOLD/RECOVER SHALL complete the current byte first (no truncated strobe).
REQ-033 start while busy SHALL be ignored.
REQ-034 busy=1 in every state except IDLE.
REQ-035 p_westb_b and p_selectData SHALL be driven from flops (glitch-free).
REQ-036 Two-byte mode: p_full stays low between byte 0 and byte 1 and rises after byte 1; no special sequencing beyond REQ-026/030 is needed.
REQ-037 Per-byte minimum period SHALL be 1+STROBE_CYCLES+1+2+SETTLE_CYCLES cycles (7 with defaults).

Reset
REQ-038 While h_rst_b=0, outputs SHALL be: state=IDLE, p_westb_b=1, p_selectData=0, p_data=8'h00, s_ready=0, busy=0, done=0, aborted=0, err=0, remaining=0; synchroniser flops=1 (treated as full).
REQ-039 Reset mid-STROBE SHALL release p_westb_b high asynchronously; the partial write is abandoned and no done is issued.

Structure
REQ-040 Shared package tube_pkg SHALL hold the FSM state enumeration and the STROBE_CYCLES/SETTLE_CYCLES defaults.
REQ-041 The synchroniser SHALL be the sub-module tube_sync2 (2-flop, async active-low reset to a parameterised value).
REQ-042 One down-counter SHALL be shared by STROBE and RECOVER timing.

Verification
REQ-043 One-byte mode, count=3, bytes 8'h11/22/33, register-3 model drains within 10 cycles -> three strobes each 2 cycles low, data latched in order, done after 3rd, remaining 3->2->1->0.
REQ-044 Two-byte mode, count=4 -> 2 strobes, then stall until the model drains both bytes, then 2 strobes; done with aborted=0.
REQ-045 Two-byte mode, count=5 -> err pulse, no strobes, busy stays 0; count=0 -> done pulse, no strobes.
REQ-046 abort asserted mid-STROBE of byte 2 of 6 -> byte 2 strobe completes at full width, done with aborted=1, remaining=4.
REQ-047 s_valid gapped randomly, p_full held high 50 cycles -> no strobe while p_full_s=1, no byte lost or duplicated.
REQ-048 h_rst_b low during STROBE -> p_westb_b high within the same cycle, all outputs at REQ-038 values, and the next start operates normally.

Source files
------------

// File: rtl/tube_pkg.sv
// -----------------------------------------------------------------------------
// tube_pkg
// Shared definitions for the register-3 feeder: FSM state encoding, the
// default strobe/settle timings and the width of the shared phase timer.
// -----------------------------------------------------------------------------
package tube_pkg;

  localparam int unsigned STROBE_CYCLES_DEF = 2;
  localparam int unsigned SETTLE_CYCLES_DEF = 1;

  // Phase timer must hold STROBE_CYCLES-1 (max 14) and 2+SETTLE_CYCLES-1 (max 16).
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    SETUP      = 3'd2,
    STROBE     = 3'd3,
    HOLD       = 3'd4,
    RECOVER    = 3'd5,
    DONE       = 3'd6
  } feeder_state_e;

  // States in which the register-3 data select is asserted.
  function automatic logic sel_active(feeder_state_e s);
    return (s == SETUP) || (s == STROBE) || (s == HOLD);
  endfunction

endpackage

// File: rtl/ph_reg3_feeder_if.sv
// -----------------------------------------------------------------------------
// ph_reg3_feeder_if
// Bundles the source byte stream and the register-3 parasite bus.
//   s_data/s_valid/s_ready : byte source handshake (source -> feeder)
//   p_data/p_selectData/p_westb_b/p_full : register-3 write port and full flag
// master = feeder side, slave = source + register-3 side.
// -----------------------------------------------------------------------------
interface ph_reg3_feeder_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  logic [7:0] p_data;
  logic       p_selectData;
  logic       p_westb_b;
  logic       p_full;

  modport master (
    input  s_data, s_valid, p_full,
    output s_ready, p_data, p_selectData, p_westb_b
  );

  modport slave (
    output s_data, s_valid, p_full,
    input  s_ready, p_data, p_selectData, p_westb_b
  );

endinterface

// File: rtl/tube_sync2.sv
// -----------------------------------------------------------------------------
// tube_sync2
// Two-flop synchroniser with asynchronous active-low reset to RST_VAL.
//   i_clk   : destination clock
//   i_rst_b : async reset, active low
//   i_d     : asynchronous input
//   o_q     : synchronised output
// -----------------------------------------------------------------------------
module tube_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ph_reg3_feeder.sv
// -----------------------------------------------------------------------------
// ph_reg3_feeder
// Feeds a block of bytes from a valid/ready source into the register-3
// parasite FIFO, one strobed write per byte, pacing on the synchronised
// register-3 full flag.
//
// Ports:
//   p_clk         : parasite-side clock
//   h_rst_b       : async reset, active low
//   start         : one-cycle request to begin a block transfer
//   byte_count    : bytes to transfer (sampled with start)
//   one_byte_mode : register-3 V-flag mode (sampled with start)
//   abort         : level request to end the transfer early
//   busy          : transfer in progress
//   done          : one-cycle completion pulse
//   aborted       : qualifies done, set when ended by abort
//   err           : one-cycle pulse on a rejected start
//   remaining     : bytes still to be written
//   bus           : source stream + register-3 bus (master side)
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_SPACE | waiting for register-3 space and a source byte
// SETUP      | byte presented, select high, strobe high, source byte accepted
// STROBE     | write strobe low for STROBE_CYCLES
// HOLD       | strobe released, data/select held past the latch edge
// RECOVER    | select low while the full flag crosses the synchroniser
// DONE       | completion pulse
// -----------------------------------------------------------------------------
module ph_reg3_feeder
  import tube_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic                  p_clk,
  input  logic                  h_rst_b,
  input  logic                  start,
  input  logic [15:0]           byte_count,
  input  logic                  one_byte_mode,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err,
  output logic [15:0]           remaining,
  ph_reg3_feeder_if.master      bus
);

  localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(2 + SETTLE_CYCLES - 1);

  feeder_state_e    r_state;
  feeder_state_e    w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_rem;
  logic             r_abort_pend;

  logic             r_westb_b;
  logic             r_sel;
  logic             r_s_ready;
  logic [7:0]       r_p_data;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_err;

  logic             w_full_s;
  logic             w_zero_req;
  logic             w_odd_req;
  logic             w_start_ok;
  logic             w_load;
  logic             w_dec;
  logic             w_finish;

  tube_sync2 #(.RST_VAL(1'b1)) u_full_sync (
    .i_clk   (p_clk),
    .i_rst_b (h_rst_b),
    .i_d     (bus.p_full),
    .o_q     (w_full_s)
  );

  // Mode only matters for start validation: two-byte mode needs an even count.
  assign w_zero_req = start && (byte_count == 16'd0);
  assign w_odd_req  = start && !one_byte_mode && byte_count[0];
  assign w_start_ok = start && !w_zero_req && !w_odd_req;

  // Abort is a level but may drop before the byte in flight finishes,
  // so the pending flag keeps it until RECOVER can act on it.
  assign w_finish = (r_rem == 16'd0) || abort || r_abort_pend;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_load    = 1'b0;
    w_dec     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_next = WAIT_SPACE;
          w_load = 1'b1;
        end
      end
      WAIT_SPACE: begin
        if (abort) begin
          w_next = DONE;
        end else if (!w_full_s && bus.s_valid) begin
          w_next = SETUP;
        end
      end
      SETUP: begin
        w_next    = STROBE;
        w_cnt_nxt = STB_LOAD;
      end
      STROBE: begin
        if (r_cnt == '0) begin
          w_next = HOLD;
          w_dec  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        w_next    = RECOVER;
        w_cnt_nxt = REC_LOAD;
      end
      RECOVER: begin
        if (r_cnt == '0) begin
          if (w_finish) begin
            w_next = DONE;
          // Same test WAIT_SPACE would make, taken here so back-to-back
          // bytes run at the minimum per-byte period.
          end else if (!w_full_s && bus.s_valid) begin
            w_next = SETUP;
          end else begin
            w_next = WAIT_SPACE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge p_clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem        <= 16'd0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_rem <= byte_count;
      end else if (w_dec) begin
        r_rem <= r_rem - 16'd1;
      end
      if (r_state == IDLE) begin
        r_abort_pend <= 1'b0;
      end else if (abort) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  // Bus and status outputs are registered decodes of the next state so
  // that strobe and select come straight from flops.
  always_ff @(posedge p_clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      r_westb_b <= 1'b1;
      r_sel     <= 1'b0;
      r_s_ready <= 1'b0;
      r_p_data  <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_westb_b <= (w_next != STROBE);
      r_sel     <= sel_active(w_next);
      r_s_ready <= (w_next == SETUP);
      // Data is captured as SETUP is entered so it is stable for a full
      // cycle before the strobe falls; the source holds it until s_ready.
      if ((w_next == SETUP) && (r_state != SETUP)) begin
        r_p_data <= bus.s_data;
      end
      r_busy    <= (w_next != IDLE);
      r_done    <= (w_next == DONE) || ((r_state == IDLE) && w_zero_req);
      r_aborted <= (w_next == DONE) && (r_state != IDLE) && (abort || r_abort_pend);
      r_err     <= (r_state == IDLE) && w_odd_req;
    end
  end

  assign bus.p_westb_b    = r_westb_b;
  assign bus.p_selectData = r_sel;
  assign bus.s_ready      = r_s_ready;
  assign bus.p_data       = r_p_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign aborted          = r_aborted;
  assign err              = r_err;
  assign remaining        = r_rem;

endmodule

// File: tb/tb_ph_reg3_feeder.sv
// -----------------------------------------------------------------------------
// tb_ph_reg3_feeder
// Directed bench for ph_reg3_feeder: a table of block transfers plus
// hand-written abort, full-stall and reset sequences, with a register-3
// model that checks every latched byte.
// -----------------------------------------------------------------------------
module tb_ph_reg3_feeder;
  import tube_pkg::*;

  localparam int STB   = 2;
  localparam int DRAIN = 6;

  typedef struct {
    logic [15:0] cnt;
    logic        mode;
    logic        gap;
    logic [7:0]  base;
    logic        exp_done;
    logic        exp_err;
    logic        exp_aborted;
    logic [15:0] exp_rem;
    int          exp_strobes;
    logic        exp_busy;
  } vec_t;

  logic        p_clk = 1'b0;
  logic        h_rst_b = 1'b0;
  logic        start = 1'b0;
  logic [15:0] byte_count = 16'd0;
  logic        one_byte_mode = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, aborted, err;
  logic [15:0] remaining;

  ph_reg3_feeder_if bus ();

  ph_reg3_feeder #(.STROBE_CYCLES(STB), .SETTLE_CYCLES(1)) dut (
    .p_clk         (p_clk),
    .h_rst_b       (h_rst_b),
    .start         (start),
    .byte_count    (byte_count),
    .one_byte_mode (one_byte_mode),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .err           (err),
    .remaining     (remaining),
    .bus           (bus)
  );

  always #5 p_clk = ~p_clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit         gap_en = 0;
  bit         force_full = 0;
  bit         model_full = 0;
  bit         model_mode = 1;
  int         drain_cnt = 0;
  int         strobe_cnt = 0;
  int         low_cnt = 0;
  int         pair_cnt = 0;
  int         model_rem = 0;
  logic       prev_westb = 1'b1;

  bit          e_done, e_err, e_ab, e_busy;
  logic [15:0] e_rem;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register-3 model: latches on the strobe rising edge, raises full after
  // every byte (one-byte mode) or every second byte (two-byte mode).
  initial begin
    bus.p_full = 1'b0;
    forever begin
      @(negedge p_clk);
      if (!h_rst_b) begin
        prev_westb = bus.p_westb_b;
        low_cnt    = 0;
        model_full = 0;
        drain_cnt  = 0;
      end else begin
        if (drain_cnt > 0) begin
          drain_cnt--;
          if (drain_cnt == 0) model_full = 0;
        end
        if (!prev_westb && bus.p_westb_b) begin
          strobe_cnt++;
          chk("strobe_width", low_cnt, STB);
          chk("select_at_latch", bus.p_selectData, 1);
          chk("byte_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("latched_data", bus.p_data, exp_q.pop_front());
          model_rem--;
          chk("remaining_at_latch", remaining, model_rem);
          pair_cnt++;
          if (model_mode || (pair_cnt % 2 == 0)) begin
            model_full = 1;
            drain_cnt  = DRAIN;
          end
        end
        low_cnt    = bus.p_westb_b ? 0 : low_cnt + 1;
        prev_westb = bus.p_westb_b;
      end
      bus.p_full = force_full | model_full;
    end
  end

  // Byte source: holds valid until accepted, optional random gaps.
  initial begin
    logic [7:0] dummy;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    forever begin
      @(negedge p_clk);
      if (h_rst_b && bus.s_valid && bus.s_ready) begin
        if (src_q.size() > 0) dummy = src_q.pop_front();
        bus.s_valid = 1'b0;
      end
      if (!bus.s_valid && src_q.size() > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
        bus.s_data  = src_q[0];
        bus.s_valid = 1'b1;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_westb"}, bus.p_westb_b, 1);
    chk({tag, "_sel"}, bus.p_selectData, 0);
    chk({tag, "_pdata"}, bus.p_data, 0);
    chk({tag, "_sready"}, bus.s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_remaining"}, remaining, 0);
  endtask

  task automatic wait_end(input string tag, input int budget);
    e_done = 0; e_err = 0; e_ab = 0; e_busy = 0; e_rem = 16'd0;
    for (int c = 0; c < budget; c++) begin
      e_busy |= busy;
      if (done || err) begin
        e_done = done; e_err = err; e_ab = aborted; e_rem = remaining;
        break;
      end
      @(negedge p_clk);
    end
    chk({tag, "_ended_in_budget"}, e_done | e_err, 1);
  endtask

  task automatic load_bytes(input logic [15:0] n, input logic [7:0] base);
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      logic [7:0] b;
      b = base + 8'(i * 8'h11);
      src_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic flush_source();
    src_q.delete();
    exp_q.delete();
    bus.s_valid = 1'b0;
  endtask

  task automatic issue_start(input logic [15:0] n, input logic mode);
    @(negedge p_clk);
    start = 1'b1; byte_count = n; one_byte_mode = mode;
    @(negedge p_clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    if (!v.exp_err) load_bytes(v.cnt, v.base);
    else flush_source();
    model_mode = v.mode; model_rem = int'(v.cnt); pair_cnt = 0; strobe_cnt = 0;
    gap_en = v.gap;
    issue_start(v.cnt, v.mode);
    wait_end(tag, 3000);
    chk({tag, "_done"}, e_done, v.exp_done);
    chk({tag, "_err"}, e_err, v.exp_err);
    chk({tag, "_aborted"}, e_ab, v.exp_aborted);
    chk({tag, "_remaining"}, e_rem, v.exp_rem);
    for (int c = 0; c < 20; c++) begin
      e_busy |= busy;
      @(negedge p_clk);
    end
    chk({tag, "_busy_seen"}, e_busy, v.exp_busy);
    chk({tag, "_strobes"}, strobe_cnt, v.exp_strobes);
    chk({tag, "_bytes_left"}, exp_q.size(), 0);
    gap_en = 0;
  endtask

  initial begin
    vec_t vecs[9];
    vec_t rv;
    int   snap;
    bit   seen;
    //            cnt    mode  gap   base   done  err   ab    rem    strb busy
    vecs[0] = '{16'd3, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 16'd0, 3, 1'b1};
    vecs[1] = '{16'd4, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 16'd0, 4, 1'b1};
    vecs[2] = '{16'd5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0, 0, 1'b0};
    vecs[3] = '{16'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0};
    vecs[4] = '{16'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0};
    vecs[5] = '{16'd1, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, 1'b0, 16'd0, 1, 1'b1};
    vecs[6] = '{16'd2, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 16'd0, 2, 1'b1};
    vecs[7] = '{16'd5, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 16'd0, 5, 1'b1};
    vecs[8] = '{16'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0, 0, 1'b0};

    #12;
    chk_reset_outputs("reset");
    @(negedge p_clk);
    h_rst_b = 1'b1;
    repeat (4) @(negedge p_clk);

    for (int i = 0; i < 9; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Abort while byte 2 of 6 is strobing.
    load_bytes(16'd6, 8'h60);
    model_mode = 1; model_rem = 6; pair_cnt = 0; strobe_cnt = 0;
    issue_start(16'd6, 1'b1);
    seen = 0;
    for (int c = 0; c < 500; c++) begin
      if (strobe_cnt >= 1 && !bus.p_westb_b) begin seen = 1; break; end
      @(negedge p_clk);
    end
    chk("abort_found_strobe2", seen, 1);
    abort = 1'b1;
    wait_end("abort_strobe", 500);
    chk("abort_strobe_aborted", e_ab, 1);
    chk("abort_strobe_remaining", e_rem, 4);
    chk("abort_strobe_strobes", strobe_cnt, 2);
    abort = 1'b0;
    flush_source();
    repeat (20) @(negedge p_clk);

    // Abort while stalled in WAIT_SPACE.
    force_full = 1;
    repeat (4) @(negedge p_clk);
    load_bytes(16'd2, 8'h70);
    model_mode = 1; model_rem = 2; pair_cnt = 0; strobe_cnt = 0;
    issue_start(16'd2, 1'b1);
    repeat (5) @(negedge p_clk);
    chk("wait_space_busy", busy, 1);
    abort = 1'b1;
    wait_end("abort_wait", 100);
    chk("abort_wait_aborted", e_ab, 1);
    chk("abort_wait_remaining", e_rem, 2);
    chk("abort_wait_strobes", strobe_cnt, 0);
    abort = 1'b0;
    force_full = 0;
    flush_source();
    repeat (20) @(negedge p_clk);

    // Gapped source, p_full held high for 50 cycles, start while busy ignored.
    load_bytes(16'd8, 8'h81);
    model_mode = 1; model_rem = 8; pair_cnt = 0; strobe_cnt = 0; gap_en = 1;
    issue_start(16'd8, 1'b1);
    seen = 0;
    for (int c = 0; c < 1000; c++) begin
      if (strobe_cnt >= 2) begin seen = 1; break; end
      @(negedge p_clk);
    end
    chk("stall_reached_byte2", seen, 1);
    force_full = 1;
    repeat (6) @(negedge p_clk);
    snap = strobe_cnt;
    issue_start(16'd9, 1'b1);
    repeat (42) @(negedge p_clk);
    chk("stall_no_strobe_while_full", strobe_cnt, snap);
    chk("stall_busy_held", busy, 1);
    force_full = 0;
    wait_end("stall", 2000);
    chk("stall_done", e_done, 1);
    chk("stall_aborted", e_ab, 0);
    chk("stall_remaining", e_rem, 0);
    repeat (20) @(negedge p_clk);
    chk("stall_strobes", strobe_cnt, 8);
    chk("stall_bytes_left", exp_q.size(), 0);
    chk("stall_src_left", src_q.size(), 0);
    gap_en = 0;

    // Reset asserted mid-strobe.
    load_bytes(16'd4, 8'h90);
    model_mode = 1; model_rem = 4; pair_cnt = 0; strobe_cnt = 0;
    issue_start(16'd4, 1'b1);
    seen = 0;
    for (int c = 0; c < 500; c++) begin
      if (strobe_cnt >= 1 && !bus.p_westb_b) begin seen = 1; break; end
      @(negedge p_clk);
    end
    chk("rst_found_strobe", seen, 1);
    #2 h_rst_b = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    flush_source();
    repeat (3) @(negedge p_clk);
    h_rst_b = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      seen |= done;
      @(negedge p_clk);
    end
    chk("rst_no_done", seen, 0);
    rv = '{16'd2, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 16'd0, 2, 1'b1};
    run_xfer(rv, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
